// File: rtl/fetch_unit_pkg.sv
// Shared pipeline constants and types used by the fetch, operand-fetch and execute stages.
package fetch_unit_pkg;

    localparam int unsigned INST_WIDTH = 32;

    typedef logic [INST_WIDTH-1:0] word_t;

    localparam word_t NOP_INST = 32'h6800_0000;
    localparam word_t PC_STEP  = 32'd4;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory bus: fetch side is master (address/enable), memory is slave (read data).
interface fetch_unit_if;

    fetch_unit_pkg::word_t imem_addr;
    logic                  imem_en;
    fetch_unit_pkg::word_t imem_rdata;

    modport master (
        output imem_addr,
        output imem_en,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        input  imem_en,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, stall hold, branch redirect,
// and a tag register pairing the synchronous memory output with its PC.
module fetch_unit #(
    parameter fetch_unit_pkg::word_t RESET_PC = 32'h0000_0000,
    parameter fetch_unit_pkg::word_t NOP_INST = fetch_unit_pkg::NOP_INST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  isBranchTaken,
    input  fetch_unit_pkg::word_t branchPC,
    output fetch_unit_pkg::word_t pc,
    output fetch_unit_pkg::word_t inst,
    output logic                  valid,
    fetch_unit_if.master          imem
);

    import fetch_unit_pkg::*;

    word_t fpc_q;
    word_t fpc_d;
    word_t tag_pc_q;
    word_t tag_pc_d;
    logic  tag_valid_q;
    logic  tag_valid_d;

    // Next-state selection: redirect beats stall; a stall freezes fetch and tag together.
    always_comb begin
        fpc_d       = fpc_q;
        tag_pc_d    = tag_pc_q;
        tag_valid_d = tag_valid_q;
        if (isBranchTaken) begin
            // The fetch already in flight belongs to the wrong path, so it is squashed.
            fpc_d       = branchPC;
            tag_valid_d = 1'b0;
        end else if (!stall) begin
            fpc_d       = fpc_q + PC_STEP;
            tag_pc_d    = fpc_q;
            tag_valid_d = 1'b1;
        end
    end

    // State registers with synchronous reset overriding stall and redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q       <= RESET_PC;
            tag_pc_q    <= '0;
            tag_valid_q <= 1'b0;
        end else begin
            fpc_q       <= fpc_d;
            tag_pc_q    <= tag_pc_d;
            tag_valid_q <= tag_valid_d;
        end
    end

    // Memory request and pipeline-facing outputs; disabling the read on stall keeps rdata stable.
    always_comb begin
        imem.imem_addr = fpc_q;
        imem.imem_en   = ~stall | isBranchTaken | rst;
        pc             = tag_pc_q;
        valid          = tag_valid_q;
        inst           = tag_valid_q ? imem.imem_rdata : NOP_INST;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized stimulus
// against a program-order reference model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h6800_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] bpc;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic        en_seen;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model: next address to fetch, and the instruction (if any) being presented.
    logic [31:0] m_next;
    logic        m_has;
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    fetch_unit_if imem_if ();

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .isBranchTaken (br),
        .branchPC      (bpc),
        .pc            (pc),
        .inst          (inst),
        .valid         (valid),
        .imem          (imem_if)
    );

    // Synchronous memory: word at byte address a holds a >> 2.
    always @(posedge clk) begin
        if (imem_if.imem_en) imem_if.imem_rdata <= imem_if.imem_addr >> 2;
    end

    function automatic logic [31:0] m_inst();
        return m_has ? (m_pc >> 2) : NOP;
    endfunction

    // Apply one cycle of inputs, sample the read enable mid-cycle, advance the model at the edge.
    task automatic tick(input logic r, input logic s, input logic b, input logic [31:0] t);
        rst = r; stall = s; br = b; bpc = t;
        #2;
        en_seen = imem_if.imem_en;
        @(posedge clk);
        if (r) begin
            m_next = RESET_PC; m_has = 1'b0; m_pc = '0;
        end else if (b) begin
            m_next = t; m_has = 1'b0;
        end else if (!s) begin
            m_has = 1'b1; m_pc = m_next; m_next = m_next + 32'd4;
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, 1'b0, '0);
        tick(1'b1, 1'b1, 1'b1, 32'h1234);
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", valid); end
        n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", pc); end
        n_tests++; if (inst !== NOP) begin n_fail++; $display("FAIL reset_inst got %h want %h", inst, NOP); end
        n_tests++; if (imem_if.imem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_addr got %h want %h", imem_if.imem_addr, RESET_PC); end
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0, 1'b0, '0);
            n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL run_valid[%0d] got %0b want 1", k, valid); end
            n_tests++; if (pc !== 32'(4 * k)) begin n_fail++; $display("FAIL run_pc[%0d] got %h want %h", k, pc, 32'(4 * k)); end
            n_tests++; if (inst !== 32'(k)) begin n_fail++; $display("FAIL run_inst[%0d] got %h want %h", k, inst, 32'(k)); end
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b1, 1'b0, '0);
            n_tests++; if (pc !== 32'd8 || inst !== 32'd2 || valid !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold[%0d] got pc=%h inst=%h v=%0b want pc=8 inst=2 v=1", k, pc, inst, valid);
            end
            n_tests++; if (en_seen !== 1'b0) begin n_fail++; $display("FAIL stall_en[%0d] got %0b want 0", k, en_seen); end
        end
        tick(1'b0, 1'b0, 1'b0, '0);
        n_tests++; if (pc !== 32'd12 || inst !== 32'd3) begin
            n_fail++; $display("FAIL stall_resume got pc=%h inst=%h want pc=c inst=3", pc, inst);
        end
    endtask

    task automatic test_redirect();
        tick(1'b0, 1'b0, 1'b1, 32'h100);
        n_tests++; if (valid !== 1'b0 || inst !== NOP) begin
            n_fail++; $display("FAIL redir_squash got v=%0b inst=%h want v=0 inst=%h", valid, inst, NOP);
        end
        n_tests++; if (imem_if.imem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_addr got %h want 100", imem_if.imem_addr); end
        tick(1'b0, 1'b0, 1'b0, '0);
        n_tests++; if (pc !== 32'h100 || valid !== 1'b1 || inst !== 32'h40) begin
            n_fail++; $display("FAIL redir_target got pc=%h v=%0b inst=%h want pc=100 v=1 inst=40", pc, valid, inst);
        end
    endtask

    task automatic test_simultaneous();
        tick(1'b0, 1'b1, 1'b1, 32'h40);
        n_tests++; if (en_seen !== 1'b1) begin n_fail++; $display("FAIL simul_en got %0b want 1", en_seen); end
        n_tests++; if (imem_if.imem_addr !== 32'h40 || valid !== 1'b0) begin
            n_fail++; $display("FAIL simul_redir got addr=%h v=%0b want addr=40 v=0", imem_if.imem_addr, valid);
        end
        tick(1'b0, 1'b0, 1'b0, '0);
        n_tests++; if (pc !== 32'h40 || inst !== 32'h10) begin
            n_fail++; $display("FAIL simul_target got pc=%h inst=%h want pc=40 inst=10", pc, inst);
        end
    endtask

    task automatic test_wrap();
        tick(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        tick(1'b0, 1'b0, 1'b0, '0);
        n_tests++; if (pc !== 32'hFFFF_FFFC || inst !== 32'h3FFF_FFFF) begin
            n_fail++; $display("FAIL wrap_top got pc=%h inst=%h want pc=fffffffc inst=3fffffff", pc, inst);
        end
        n_tests++; if (imem_if.imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr got %h want 0", imem_if.imem_addr); end
        tick(1'b0, 1'b0, 1'b0, '0);
        n_tests++; if (pc !== 32'h0 || valid !== 1'b1 || inst !== 32'h0) begin
            n_fail++; $display("FAIL wrap_zero got pc=%h v=%0b inst=%h want pc=0 v=1 inst=0", pc, valid, inst);
        end
    endtask

    task automatic test_midrun_reset();
        tick(1'b0, 1'b0, 1'b1, 32'h20);
        tick(1'b0, 1'b0, 1'b0, '0);
        tick(1'b0, 1'b1, 1'b0, '0);
        n_tests++; if (pc !== 32'h20 || valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_setup got pc=%h v=%0b want pc=20 v=1", pc, valid);
        end
        tick(1'b1, 1'b1, 1'b0, '0);
        n_tests++; if (en_seen !== 1'b1) begin n_fail++; $display("FAIL mid_en got %0b want 1", en_seen); end
        n_tests++; if (valid !== 1'b0 || pc !== 32'h0 || inst !== NOP || imem_if.imem_addr !== RESET_PC) begin
            n_fail++; $display("FAIL mid_reset got v=%0b pc=%h inst=%h addr=%h want v=0 pc=0 inst=%h addr=%h",
                               valid, pc, inst, imem_if.imem_addr, NOP, RESET_PC);
        end
        tick(1'b0, 1'b0, 1'b0, '0);
        n_tests++; if (pc !== RESET_PC || valid !== 1'b1 || inst !== 32'h0) begin
            n_fail++; $display("FAIL mid_restart got pc=%h v=%0b inst=%h want pc=%h v=1 inst=0", pc, valid, inst, RESET_PC);
        end
    endtask

    task automatic test_random();
        logic        r, s, b;
        logic [31:0] t;
        logic        exp_en;
        for (int k = 0; k < 400; k++) begin
            r = ($urandom_range(0, 31) == 0);
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 7) == 0);
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            exp_en = r | b | ~s;
            tick(r, s, b, t);
            n_tests++; if (en_seen !== exp_en) begin n_fail++; $display("FAIL rnd_en[%0d] got %0b want %0b", k, en_seen, exp_en); end
            n_tests++; if (valid !== m_has || (m_has && pc !== m_pc) || (!m_has && r && pc !== 32'h0)) begin
                n_fail++; $display("FAIL rnd_pc[%0d] got pc=%h v=%0b want pc=%h v=%0b", k, pc, valid, m_pc, m_has);
            end
            n_tests++; if (inst !== m_inst()) begin n_fail++; $display("FAIL rnd_inst[%0d] got %h want %h", k, inst, m_inst()); end
            n_tests++; if (imem_if.imem_addr !== m_next) begin
                n_fail++; $display("FAIL rnd_addr[%0d] got %h want %h", k, imem_if.imem_addr, m_next);
            end
        end
    endtask

    initial begin
        m_next = RESET_PC; m_has = 1'b0; m_pc = '0;
        test_reset();
        test_stall();
        test_redirect();
        test_simultaneous();
        test_wrap();
        test_midrun_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
